// File: rtl/exec_branch_redirect.sv
// -----------------------------------------------------------------------------
// exec_branch_redirect
//
// Execute-stage branch resolution and per-thread PC redirect queue.
// Resolves beq/bneq for the issuing thread. Each hardware thread can hold one
// pending redirect. Pending redirects go to fetch over a single valid/ready
// channel, chosen round-robin. Any thread that still has an unaccepted redirect
// has its younger instructions squashed.
//
// Ports:
//   clk, reset            clock; synchronous active-low reset
//   en, valid_in          stage enable / live pipeline-register contents
//   pc_in, branch_offset_in  PC and PC-relative offset of the executing insn
//   R1_data_in, R2_data_in   compare operands
//   beq_in, bneq_in       branch type (both set = no branch)
//   thread_id_in          issuing thread
//   redirect_ready        fetch accepts the presented redirect
//   squash_out            combinational: current instruction must not commit
//   redirect_valid/_pc/_thread  registered redirect channel to fetch
//   flush_threads         registered per-thread pending mask
//   taken_count           saturating taken-branch counter
// -----------------------------------------------------------------------------
module exec_branch_redirect #(
    parameter int DATAPATH_WIDTH  = 64,
    parameter int INST_ADDR_WIDTH = 9,
    parameter int THREAD_BITS     = 2,
    parameter int COUNT_WIDTH     = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        en,
    input  logic                        valid_in,
    input  logic [INST_ADDR_WIDTH-1:0]  pc_in,
    input  logic [DATAPATH_WIDTH-1:0]   R1_data_in,
    input  logic [DATAPATH_WIDTH-1:0]   R2_data_in,
    input  logic                        beq_in,
    input  logic                        bneq_in,
    input  logic [INST_ADDR_WIDTH-1:0]  branch_offset_in,
    input  logic [THREAD_BITS-1:0]      thread_id_in,
    input  logic                        redirect_ready,
    output logic                        squash_out,
    output logic                        redirect_valid,
    output logic [INST_ADDR_WIDTH-1:0]  redirect_pc,
    output logic [THREAD_BITS-1:0]      redirect_thread,
    output logic [2**THREAD_BITS-1:0]   flush_threads,
    output logic [COUNT_WIDTH-1:0]      taken_count
);

    localparam int NUM_THREADS = 2**THREAD_BITS;

    // State
    logic [NUM_THREADS-1:0]     pend_valid_q, pend_valid_d;
    logic [INST_ADDR_WIDTH-1:0] pend_pc_q [NUM_THREADS];
    logic [INST_ADDR_WIDTH-1:0] pend_pc_d [NUM_THREADS];
    logic                       redirect_valid_q, redirect_valid_d;
    logic [INST_ADDR_WIDTH-1:0] redirect_pc_q, redirect_pc_d;
    logic [THREAD_BITS-1:0]     redirect_thread_q, redirect_thread_d;
    logic [NUM_THREADS-1:0]     flush_threads_q, flush_threads_d;
    logic [COUNT_WIDTH-1:0]     taken_count_q, taken_count_d;
    logic [THREAD_BITS-1:0]     rr_ptr_q, rr_ptr_d;

    // Combinational helpers
    logic                       live;
    logic                       ops_equal;
    logic                       taken;
    logic                       accept;
    logic [INST_ADDR_WIDTH-1:0] target;
    logic [NUM_THREADS-1:0]     eligible;
    logic                       grant_found;
    logic [THREAD_BITS-1:0]     grant_thread;
    logic [THREAD_BITS-1:0]     cand_idx;

    always_comb begin
        live       = en & valid_in;
        squash_out = live & pend_valid_q[thread_id_in];
        ops_equal  = (R1_data_in == R2_data_in);
        taken      = live & ~squash_out &
                     ((beq_in & ~bneq_in & ops_equal) |
                      (bneq_in & ~beq_in & ~ops_equal));
        target     = pc_in + branch_offset_in;
        accept     = redirect_valid_q & redirect_ready;

        // Slots still waiting after this edge's acceptance. A branch taken
        // this cycle is deliberately excluded: it competes from the next edge.
        eligible = pend_valid_q;
        if (accept) begin
            eligible[redirect_thread_q] = 1'b0;
        end

        pend_valid_d = eligible;
        pend_pc_d    = pend_pc_q;
        if (taken) begin
            pend_valid_d[thread_id_in] = 1'b1;
            pend_pc_d[thread_id_in]    = target;
        end

        // Round-robin search beginning at rr_ptr_q (one past the last grant).
        grant_found  = 1'b0;
        grant_thread = '0;
        cand_idx     = '0;
        for (int unsigned i = 0; i < NUM_THREADS; i++) begin
            cand_idx = rr_ptr_q + THREAD_BITS'(i);
            if (!grant_found && eligible[cand_idx]) begin
                grant_found  = 1'b1;
                grant_thread = cand_idx;
            end
        end

        redirect_valid_d  = redirect_valid_q;
        redirect_pc_d     = redirect_pc_q;
        redirect_thread_d = redirect_thread_q;
        rr_ptr_d          = rr_ptr_q;
        if (!redirect_valid_q || accept) begin
            redirect_valid_d = grant_found;
            if (grant_found) begin
                redirect_pc_d     = pend_pc_q[grant_thread];
                redirect_thread_d = grant_thread;
                rr_ptr_d          = grant_thread + 1'b1;
            end
        end

        flush_threads_d = pend_valid_d;

        taken_count_d = taken_count_q;
        if (taken && (taken_count_q != '1)) begin
            taken_count_d = taken_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pend_valid_q      <= '0;
            for (int unsigned i = 0; i < NUM_THREADS; i++) begin
                pend_pc_q[i] <= '0;
            end
            redirect_valid_q  <= 1'b0;
            redirect_pc_q     <= '0;
            redirect_thread_q <= '0;
            flush_threads_q   <= '0;
            taken_count_q     <= '0;
            rr_ptr_q          <= '0;
        end else begin
            pend_valid_q      <= pend_valid_d;
            for (int unsigned i = 0; i < NUM_THREADS; i++) begin
                pend_pc_q[i] <= pend_pc_d[i];
            end
            redirect_valid_q  <= redirect_valid_d;
            redirect_pc_q     <= redirect_pc_d;
            redirect_thread_q <= redirect_thread_d;
            flush_threads_q   <= flush_threads_d;
            taken_count_q     <= taken_count_d;
            rr_ptr_q          <= rr_ptr_d;
        end
    end

    assign redirect_valid  = redirect_valid_q;
    assign redirect_pc     = redirect_pc_q;
    assign redirect_thread = redirect_thread_q;
    assign flush_threads   = flush_threads_q;
    assign taken_count     = taken_count_q;

endmodule

// File: tb/tb_exec_branch_redirect.sv
// -----------------------------------------------------------------------------
// Testbench for exec_branch_redirect: directed scenarios with literal
// expectations plus a randomized run against a behavioural reference model.
// -----------------------------------------------------------------------------
module tb_exec_branch_redirect;

    localparam int DW  = 64;
    localparam int AW  = 9;
    localparam int TB  = 2;
    localparam int NT  = 4;
    localparam int CW  = 16;

    logic          clk;
    logic          reset;
    logic          en;
    logic          valid_in;
    logic [AW-1:0] pc_in;
    logic [DW-1:0] r1;
    logic [DW-1:0] r2;
    logic          beq;
    logic          bneq;
    logic [AW-1:0] off;
    logic [TB-1:0] tid;
    logic          ready;
    logic          squash_out;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic [TB-1:0] redirect_thread;
    logic [NT-1:0] flush_threads;
    logic [CW-1:0] taken_count;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    exec_branch_redirect #(
        .DATAPATH_WIDTH (DW),
        .INST_ADDR_WIDTH(AW),
        .THREAD_BITS    (TB),
        .COUNT_WIDTH    (CW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .en              (en),
        .valid_in        (valid_in),
        .pc_in           (pc_in),
        .R1_data_in      (r1),
        .R2_data_in      (r2),
        .beq_in          (beq),
        .bneq_in         (bneq),
        .branch_offset_in(off),
        .thread_id_in    (tid),
        .redirect_ready  (ready),
        .squash_out      (squash_out),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .redirect_thread (redirect_thread),
        .flush_threads   (flush_threads),
        .taken_count     (taken_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    bit            m_pend [NT];
    int unsigned   m_ppc  [NT];
    bit            m_rv;
    int unsigned   m_rpc;
    int unsigned   m_rt;
    int unsigned   m_rr;
    int unsigned   m_cnt;
    logic [NT-1:0] m_flush;

    function automatic bit exp_squash();
        return en && valid_in && m_pend[int'(tid)];
    endfunction

    task automatic model_step();
        bit live, sq, eq, tk, acc, found;
        bit cand [NT];
        int unsigned t;
        if (!reset) begin
            for (int k = 0; k < NT; k++) begin
                m_pend[k] = 0;
                m_ppc[k]  = 0;
            end
            m_rv = 0; m_rpc = 0; m_rt = 0; m_rr = 0; m_cnt = 0; m_flush = '0;
        end else begin
            live = en && valid_in;
            sq   = live && m_pend[int'(tid)];
            eq   = (r1 == r2);
            tk   = live && !sq && ((beq && !bneq && eq) || (bneq && !beq && !eq));
            acc  = m_rv && ready;
            cand = m_pend;
            if (acc) cand[m_rt] = 0;
            if (!m_rv || acc) begin
                found = 0;
                for (int k = 0; k < NT; k++) begin
                    t = (m_rr + k) % NT;
                    if (!found && cand[t]) begin
                        found = 1;
                        m_rpc = m_ppc[t];
                        m_rt  = t;
                        m_rr  = (t + 1) % NT;
                    end
                end
                m_rv = found;
            end
            m_pend = cand;
            if (tk) begin
                m_pend[int'(tid)] = 1;
                m_ppc[int'(tid)]  = (int'(pc_in) + int'(off)) % (1 << AW);
                if (m_cnt < (1 << CW) - 1) m_cnt = m_cnt + 1;
            end
            for (int k = 0; k < NT; k++) m_flush[k] = m_pend[k];
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_in();
        en = 1'b1; valid_in = 1'b0; beq = 1'b0; bneq = 1'b0;
    endtask

    task automatic drive_br(input int t, input int pc, input int o,
                            input logic [DW-1:0] a, input logic [DW-1:0] b,
                            input bit is_beq, input bit is_bneq);
        en = 1'b1; valid_in = 1'b1;
        tid = TB'(t); pc_in = AW'(pc); off = AW'(o);
        r1 = a; r2 = b; beq = is_beq; bneq = is_bneq;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0; ready = 1'b0;
        drive_br(0, 'h010, 'h001, 64'h55, 64'h55, 1, 0);
        tick(); tick();
        n_checks++; if (redirect_valid !== 1'b0) $display("FAIL reset_valid: got %0b want 0", redirect_valid); else n_pass++;
        n_checks++; if (redirect_pc !== '0) $display("FAIL reset_pc: got %0h want 0", redirect_pc); else n_pass++;
        n_checks++; if (redirect_thread !== '0) $display("FAIL reset_thread: got %0d want 0", redirect_thread); else n_pass++;
        n_checks++; if (flush_threads !== '0) $display("FAIL reset_flush: got %b want 0000", flush_threads); else n_pass++;
        n_checks++; if (taken_count !== '0) $display("FAIL reset_count: got %0d want 0", taken_count); else n_pass++;
        n_checks++; if (squash_out !== 1'b0) $display("FAIL reset_squash: got %0b want 0", squash_out); else n_pass++;
        reset = 1'b1;
        idle_in();
    endtask

    task automatic test_beq_taken();
        ready = 1'b0;
        drive_br(1, 'h010, 'h005, 64'hAB, 64'hAB, 1, 0);
        #1;
        n_checks++; if (squash_out !== 1'b0) $display("FAIL beq_squash: got %0b want 0", squash_out); else n_pass++;
        tick();
        idle_in();
        n_checks++; if (flush_threads !== 4'b0010) $display("FAIL beq_flush_rise: got %b want 0010", flush_threads); else n_pass++;
        n_checks++; if (redirect_valid !== 1'b0) $display("FAIL beq_valid_early: got %0b want 0", redirect_valid); else n_pass++;
        tick();
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (redirect_valid !== 1'b1) $display("FAIL beq_valid[%0d]: got %0b want 1", i, redirect_valid); else n_pass++;
            n_checks++; if (redirect_pc !== 9'h015) $display("FAIL beq_pc[%0d]: got %0h want 015", i, redirect_pc); else n_pass++;
            n_checks++; if (redirect_thread !== 2'd1) $display("FAIL beq_thread[%0d]: got %0d want 1", i, redirect_thread); else n_pass++;
            if (i < 3) tick();
        end
        ready = 1'b1;
        tick();
        ready = 1'b0;
        n_checks++; if (redirect_valid !== 1'b0) $display("FAIL beq_valid_drop: got %0b want 0", redirect_valid); else n_pass++;
        n_checks++; if (flush_threads !== 4'b0000) $display("FAIL beq_flush_fall: got %b want 0000", flush_threads); else n_pass++;
        n_checks++; if (taken_count !== 16'd1) $display("FAIL beq_count: got %0d want 1", taken_count); else n_pass++;
    endtask

    task automatic test_wrap_bneq();
        ready = 1'b0;
        drive_br(2, 'h1F0, 'h020, 64'd5, 64'd6, 0, 1);
        tick(); idle_in(); tick();
        n_checks++; if (redirect_valid !== 1'b1) $display("FAIL wrap_valid: got %0b want 1", redirect_valid); else n_pass++;
        n_checks++; if (redirect_pc !== 9'h010) $display("FAIL wrap_pc: got %0h want 010", redirect_pc); else n_pass++;
        n_checks++; if (redirect_thread !== 2'd2) $display("FAIL wrap_thread: got %0d want 2", redirect_thread); else n_pass++;
        ready = 1'b1; tick(); ready = 1'b0;
        n_checks++; if (taken_count !== 16'd2) $display("FAIL wrap_count: got %0d want 2", taken_count); else n_pass++;
        // bneq with equal operands, then both flags with equal and unequal operands
        for (int k = 0; k < 3; k++) begin
            case (k)
                0:       drive_br(2, 'h1F0, 'h020, 64'd5, 64'd5, 0, 1);
                1:       drive_br(2, 'h1F0, 'h020, 64'd7, 64'd7, 1, 1);
                default: drive_br(2, 'h1F0, 'h020, 64'd7, 64'd8, 1, 1);
            endcase
            tick(); idle_in(); tick();
            n_checks++; if (redirect_valid !== 1'b0) $display("FAIL nottaken_valid[%0d]: got %0b want 0", k, redirect_valid); else n_pass++;
            n_checks++; if (flush_threads !== 4'b0000) $display("FAIL nottaken_flush[%0d]: got %b want 0000", k, flush_threads); else n_pass++;
            n_checks++; if (taken_count !== 16'd2) $display("FAIL nottaken_count[%0d]: got %0d want 2", k, taken_count); else n_pass++;
        end
    endtask

    task automatic test_squash();
        ready = 1'b0;
        drive_br(1, 'h020, 'h004, 64'd1, 64'd1, 1, 0);
        tick();
        drive_br(1, 'h100, 'h010, 64'd3, 64'd3, 1, 0);
        #1;
        n_checks++; if (squash_out !== 1'b1) $display("FAIL squash_same_thread: got %0b want 1", squash_out); else n_pass++;
        tick();
        drive_br(0, 'h030, 'h001, 64'd1, 64'd2, 1, 0);
        #1;
        n_checks++; if (squash_out !== 1'b0) $display("FAIL squash_other_thread: got %0b want 0", squash_out); else n_pass++;
        n_checks++; if (redirect_pc !== 9'h024) $display("FAIL squash_pc_kept: got %0h want 024", redirect_pc); else n_pass++;
        n_checks++; if (taken_count !== 16'd3) $display("FAIL squash_count: got %0d want 3", taken_count); else n_pass++;
        drive_br(1, 'h100, 'h010, 64'd3, 64'd3, 1, 0);
        en = 1'b0;
        #1;
        n_checks++; if (squash_out !== 1'b0) $display("FAIL squash_en_low: got %0b want 0", squash_out); else n_pass++;
        tick();
        n_checks++; if (flush_threads !== 4'b0010) $display("FAIL en_low_flush: got %b want 0010", flush_threads); else n_pass++;
        // acceptance of thread 1 coincides with a live thread-1 instruction
        drive_br(1, 'h100, 'h010, 64'd3, 64'd3, 1, 0);
        ready = 1'b1;
        #1;
        n_checks++; if (squash_out !== 1'b1) $display("FAIL squash_on_accept: got %0b want 1", squash_out); else n_pass++;
        tick();
        idle_in(); ready = 1'b0;
        n_checks++; if (redirect_valid !== 1'b0) $display("FAIL accept_valid: got %0b want 0", redirect_valid); else n_pass++;
        n_checks++; if (flush_threads !== 4'b0000) $display("FAIL accept_flush: got %b want 0000", flush_threads); else n_pass++;
        n_checks++; if (taken_count !== 16'd3) $display("FAIL accept_count: got %0d want 3", taken_count); else n_pass++;
    endtask

    task automatic test_round_robin();
        ready = 1'b0;
        drive_br(0, 'h040, 'h002, 64'd9, 64'd9, 1, 0); tick();
        drive_br(2, 'h050, 'h003, 64'd9, 64'd9, 1, 0); tick();
        drive_br(3, 'h060, 'h004, 64'd9, 64'd9, 1, 0); tick();
        idle_in();
        n_checks++; if (flush_threads !== 4'b1101) $display("FAIL rr_flush: got %b want 1101", flush_threads); else n_pass++;
        n_checks++; if (redirect_thread !== 2'd0 || redirect_pc !== 9'h042) $display("FAIL rr_grant0: got t%0d pc %0h want t0 pc 042", redirect_thread, redirect_pc); else n_pass++;
        ready = 1'b1;
        tick();
        n_checks++; if (redirect_thread !== 2'd2 || redirect_pc !== 9'h053) $display("FAIL rr_grant2: got t%0d pc %0h want t2 pc 053", redirect_thread, redirect_pc); else n_pass++;
        drive_br(0, 'h070, 'h005, 64'd9, 64'd9, 1, 0);
        tick();
        idle_in();
        n_checks++; if (redirect_thread !== 2'd3 || redirect_pc !== 9'h064) $display("FAIL rr_grant3: got t%0d pc %0h want t3 pc 064", redirect_thread, redirect_pc); else n_pass++;
        tick();
        n_checks++; if (redirect_valid !== 1'b1 || redirect_thread !== 2'd0 || redirect_pc !== 9'h075) $display("FAIL rr_regrant0: got v%0b t%0d pc %0h want v1 t0 pc 075", redirect_valid, redirect_thread, redirect_pc); else n_pass++;
        tick();
        ready = 1'b0;
        n_checks++; if (redirect_valid !== 1'b0) $display("FAIL rr_drain: got %0b want 0", redirect_valid); else n_pass++;
        n_checks++; if (taken_count !== 16'd7) $display("FAIL rr_count: got %0d want 7", taken_count); else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            reset    = ($urandom_range(0, 149) != 0);
            en       = ($urandom_range(0, 9) != 0);
            valid_in = $urandom_range(0, 1);
            tid      = TB'($urandom);
            pc_in    = AW'($urandom);
            off      = AW'($urandom);
            beq      = $urandom_range(0, 1);
            bneq     = $urandom_range(0, 1);
            r1       = 64'($urandom_range(0, 3));
            r2       = ($urandom_range(0, 1) != 0) ? r1 : {$urandom, $urandom};
            ready    = $urandom_range(0, 1);
            #1;
            n_checks++; if (squash_out !== exp_squash()) $display("FAIL rnd_squash[%0d]: got %0b want %0b", i, squash_out, exp_squash()); else n_pass++;
            tick();
            n_checks++; if (redirect_valid !== m_rv) $display("FAIL rnd_valid[%0d]: got %0b want %0b", i, redirect_valid, m_rv); else n_pass++;
            n_checks++; if (redirect_pc !== AW'(m_rpc)) $display("FAIL rnd_pc[%0d]: got %0h want %0h", i, redirect_pc, m_rpc); else n_pass++;
            n_checks++; if (redirect_thread !== TB'(m_rt)) $display("FAIL rnd_thread[%0d]: got %0d want %0d", i, redirect_thread, m_rt); else n_pass++;
            n_checks++; if (flush_threads !== m_flush) $display("FAIL rnd_flush[%0d]: got %b want %b", i, flush_threads, m_flush); else n_pass++;
            n_checks++; if (taken_count !== CW'(m_cnt)) $display("FAIL rnd_count[%0d]: got %0d want %0d", i, taken_count, m_cnt); else n_pass++;
        end
        reset = 1'b1;
        idle_in();
        ready = 1'b0;
        tick();
    endtask

    task automatic test_saturation_and_reset();
        int cyc;
        cyc = 0;
        ready = 1'b1;
        while (m_cnt != 32'hFFFE && cyc < 90000) begin
            drive_br(cyc % NT, int'($urandom_range(0, 511)), 1, 64'd4, 64'd4, 1, 0);
            tick();
            n_checks++; if (taken_count !== CW'(m_cnt)) $display("FAIL sat_count_track[%0d]: got %0d want %0d", cyc, taken_count, m_cnt); else n_pass++;
            cyc++;
        end
        n_checks++; if (m_cnt != 32'hFFFE) $display("FAIL sat_preload_timeout: got %0d want 65534", m_cnt); else n_pass++;
        idle_in();
        tick(); tick(); tick();
        n_checks++; if (taken_count !== 16'hFFFE) $display("FAIL sat_preload: got %0h want fffe", taken_count); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            drive_br(0, 'h0A0, 'h010, 64'd1, 64'd1, 1, 0);
            tick(); idle_in(); tick(); tick();
            n_checks++; if (taken_count !== 16'hFFFF) $display("FAIL sat_count[%0d]: got %0h want ffff", k, taken_count); else n_pass++;
        end
        ready = 1'b0;
        drive_br(1, 'h111, 'h001, 64'd2, 64'd2, 1, 0);
        tick(); idle_in(); tick();
        n_checks++; if (redirect_valid !== 1'b1) $display("FAIL midrst_pre_valid: got %0b want 1", redirect_valid); else n_pass++;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        n_checks++; if (redirect_valid !== 1'b0) $display("FAIL midrst_valid: got %0b want 0", redirect_valid); else n_pass++;
        n_checks++; if (taken_count !== '0) $display("FAIL midrst_count: got %0h want 0", taken_count); else n_pass++;
        n_checks++; if (flush_threads !== '0) $display("FAIL midrst_flush: got %b want 0000", flush_threads); else n_pass++;
        n_checks++; if (redirect_pc !== '0 || redirect_thread !== '0) $display("FAIL midrst_payload: got pc %0h t%0d want 0 0", redirect_pc, redirect_thread); else n_pass++;
    endtask

    initial begin
        reset = 1'b0; en = 1'b1; valid_in = 1'b0; pc_in = '0; r1 = '0; r2 = '0;
        beq = 1'b0; bneq = 1'b0; off = '0; tid = '0; ready = 1'b0;
        for (int k = 0; k < NT; k++) begin
            m_pend[k] = 0;
            m_ppc[k]  = 0;
        end
        m_rv = 0; m_rpc = 0; m_rt = 0; m_rr = 0; m_cnt = 0; m_flush = '0;
        test_reset();
        test_beq_taken();
        test_wrap_bneq();
        test_squash();
        test_round_robin();
        test_random();
        test_saturation_and_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/exec_branch_redirect.md
Name: exec_branch_redirect

Overview:
Execute-stage consumer of the decode/execute pipeline register outputs. Resolves beq/bneq for the issuing thread and holds one pending PC redirect per hardware thread. It arbitrates pending redirects round-robin onto a single valid/ready redirect channel to fetch, and squashes younger instructions of any thread whose redirect has not yet been accepted.

Parameters:
DATAPATH_WIDTH, 64, width of R1/R2 operands
INST_ADDR_WIDTH, 9, PC / branch target width
THREAD_BITS, 2, thread id width; NUM_THREADS = 2**THREAD_BITS
COUNT_WIDTH, 16, width of taken-branch statistics counter

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-low; state cleared on a clk edge while reset==0
en  in  1  stage enable; instruction sampled only when en==1
valid_in  in  1  pipeline register holds a live instruction
pc_in  in  INST_ADDR_WIDTH  PC of executing instruction
R1_data_in  in  DATAPATH_WIDTH  first compare operand
R2_data_in  in  DATAPATH_WIDTH  second compare operand
beq_in  in  1  branch-if-equal
bneq_in  in  1  branch-if-not-equal
branch_offset_in  in  INST_ADDR_WIDTH  PC-relative offset
thread_id_in  in  THREAD_BITS  issuing thread
redirect_ready  in  1  fetch accepts redirect this cycle
squash_out  out  1  combinational: current instruction must not commit
redirect_valid  out  1  redirect presented to fetch
redirect_pc  out  INST_ADDR_WIDTH  target PC
redirect_thread  out  THREAD_BITS  thread to redirect
flush_threads  out  NUM_THREADS  per-thread flush mask, registered
taken_count  out  COUNT_WIDTH  saturating count of taken branches

Behaviour:
- Live = en & valid_in. squash_out = live & pend_valid[thread_id_in]; squashed instructions never resolve a branch.
- Taken = live & ~squash_out & ((beq_in & ~bneq_in & R1==R2) | (bneq_in & ~beq_in & R1!=R2)). beq_in & bneq_in both 1 -> not taken, no side effects.
- Target = pc_in + branch_offset_in, modulo 2**INST_ADDR_WIDTH (wrap, no carry out).
- Taken at edge N: pend_valid[t] <= 1, pend_pc[t] <= target, taken_count += 1 (saturates at all-ones, no wrap).
- Output register: when redirect_valid==0, or redirect_valid & redirect_ready, at next edge load the next pending thread, round-robin starting after the last granted thread (initial pointer: thread 0 searched first after reset). Loading clears nothing; the slot is cleared on acceptance.
- Minimum latency: taken at edge N -> redirect_valid at edge N+1.
- Handshake: redirect_valid, redirect_pc, redirect_thread held stable until redirect_ready==1 sampled with redirect_valid==1. At that edge, pend_valid[redirect_thread] <= 0. If another slot is pending, redirect_valid stays 1 with the new payload (back-to-back, one per cycle). Otherwise redirect_valid <= 0.
- Simultaneous acceptance of thread t and a live instruction of thread t in the same cycle: the instruction is squashed, because pend_valid[t] is still 1.
- Simultaneous acceptance of thread t and a taken branch of thread u≠t: both take effect; u becomes eligible for the next grant.
- flush_threads <= pend_valid next-state, registered. A bit rises at the edge after a taken branch and falls at the edge after acceptance.
- en==0: no sampling, no squash, no new pend. Arbitration and handshake continue.
- Reset (reset==0 at an edge), including mid-handshake: pend_valid=0, pend_pc=0, redirect_valid=0, redirect_pc=0, redirect_thread=0, flush_threads=0, taken_count=0, RR pointer=thread 0. The lost redirect is acceptable; all threads restart from fetch reset.

Test Plan:
- Reset: hold reset=0 two cycles with valid_in=1, beq_in=1, R1==R2 -> all outputs 0, taken_count=0.
- beq taken: thread 1, pc=0x010, offset=0x005, R1=R2=0xAB, redirect_ready=0 -> next cycle redirect_valid=1, pc=0x015, thread=1, flush_threads=4'b0010. Payload held 3 cycles. redirect_ready=1 -> valid drops next cycle, flush clears, taken_count=1.
- Wrap and bneq: thread 2, pc=0x1F0, offset=0x020, R1=5, R2=6 -> redirect_pc=0x010. Same with R1=R2 -> no redirect. beq_in=bneq_in=1 -> no redirect.
- Squash: thread 1 pending, then live thread-1 beq taken -> squash_out=1, pend_pc unchanged, taken_count unchanged. Live thread-0 instruction same cycle -> squash_out=0.
- Round-robin: threads 0, 2, 3 pending, ready=1 continuous -> grants 0, 2, 3 on consecutive cycles. A thread-0 branch arriving during the grant of 2 is granted after 3.
- Saturation and reset mid-operation: preload counter to 0xFFFE, three taken branches -> 0xFFFF. Assert reset while redirect_valid=1 -> valid=0 next edge, counter=0.
